// File: rtl/neopix_rx.sv
`timescale 1ns/1ps
// neopix_rx: WS2812 single-wire bitstream decoder feeding a small FWFT pixel FIFO.
// Define NEOPIX_RX_PASSTHRU_EN to act as one strip node (first pixel captured, rest forwarded on do_o).
module neopix_rx #(
  parameter int SYSTEM_CLOCK  = 50000000,
  parameter int BIT_THRESH_NS = 600,
  parameter int MIN_PULSE_NS  = 150,
  parameter int LATCH_NS      = 50000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        di_i,
  output logic [23:0] pix_o,
  output logic        pix_sof_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        frame_end_o,
  output logic [15:0] pix_count_o,
  output logic        overflow_o,
  output logic        bsy_o,
  output logic        do_o
);

  localparam int CLK_MHZ    = SYSTEM_CLOCK / 1000000;
  localparam int THRESH_CYC = CLK_MHZ * BIT_THRESH_NS / 1000;
  localparam int MIN_CYC    = CLK_MHZ * MIN_PULSE_NS / 1000;
  localparam int LATCH_CYC  = CLK_MHZ * LATCH_NS / 1000;
  localparam int CW         = $clog2(LATCH_CYC + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH_CYC);
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_CYC);
  localparam logic [CW-1:0] LATCH_C  = CW'(LATCH_CYC);

`ifdef NEOPIX_RX_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;
  state_t state, state_next;

  logic          sync1, sync2, line_q;
  logic          rise, fall, cnt_max;
  logic [CW-1:0] cnt;
  logic          take_bit, abort, latch, bit_val;
  logic [22:0]   shreg;
  logic [23:0]   pix_next;
  logic [4:0]    bit_cnt;
  logic          first, fwd;
  logic [15:0]   frame_cnt;
  logic          push_v, push_sof;
  logic [23:0]   push_pix;

  // line_q is the synchronised line one clock late; edges are seen one clock after sync2 moves.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      line_q <= 1'b0;
    end else begin
      sync1  <= di_i;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign rise    = sync2 & ~line_q;
  assign fall    = ~sync2 & line_q;
  assign cnt_max = (cnt == LATCH_C);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)           cnt <= '0;
    else if (rise || fall)   cnt <= '0;
    else if (!cnt_max)       cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state <= SYNC;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    abort      = 1'b0;
    latch      = 1'b0;
    case (state)
      SYNC: if (!sync2 && cnt_max) state_next = IDLE;
      IDLE: if (rise) state_next = HIGH;
      HIGH: begin
        if (fall) begin
          state_next = LOW;
          take_bit   = (cnt >= MIN_C);
        end else if (cnt_max) begin
          abort      = 1'b1;
          state_next = SYNC;
        end
      end
      LOW: begin
        if (rise) begin
          state_next = HIGH;
        end else if (cnt_max) begin
          latch      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = SYNC;
    endcase
  end

  assign bit_val  = (cnt >= THRESH_C);
  assign pix_next = {shreg, bit_val};

  // Once fwd is set (passthrough only) the remaining bits of the frame belong downstream.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      bsy_o       <= 1'b0;
      first       <= 1'b1;
      fwd         <= 1'b0;
      frame_cnt   <= '0;
      push_v      <= 1'b0;
      push_sof    <= 1'b0;
      push_pix    <= '0;
      frame_end_o <= 1'b0;
      pix_count_o <= '0;
    end else begin
      push_v      <= 1'b0;
      frame_end_o <= 1'b0;
      if (abort || latch) begin
        bit_cnt   <= '0;
        bsy_o     <= 1'b0;
        fwd       <= 1'b0;
        first     <= 1'b1;
        frame_cnt <= '0;
        if (latch && bsy_o) begin
          frame_end_o <= 1'b1;
          pix_count_o <= frame_cnt;
        end
      end else if (take_bit && !fwd) begin
        shreg <= pix_next[22:0];
        bsy_o <= 1'b1;
        if (bit_cnt == 5'd23) begin
          bit_cnt  <= '0;
          push_v   <= 1'b1;
          push_pix <= pix_next;
          push_sof <= first;
          first    <= 1'b0;
          if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
          if (PASSTHRU) fwd <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Pixel port: a word transfers on a clock edge where pix_valid_o && pix_ready_i are both high;
  // pix_valid_o never depends on pix_ready_i and the head word holds until it is taken.
  logic [24:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && pix_ready_i;
  assign wr    = push_v && (!full || pop);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr[AW-1:0]] <= {push_sof, push_pix};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_v && full && !pop) overflow_o <= 1'b1;
    end
  end

  assign pix_valid_o           = !empty;
  assign {pix_sof_o, pix_o}    = mem[rd_ptr[AW-1:0]];

`ifdef NEOPIX_RX_PASSTHRU_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) do_o <= 1'b0;
    else           do_o <= fwd & sync2;
  end
`else
  assign do_o = 1'b0;
`endif

endmodule

// File: tb/tb_neopix_rx.sv
`timescale 1ns/1ps
// tb_neopix_rx: randomized WS2812 frames against a pixel-level queue model of neopix_rx.
module tb_neopix_rx;

  localparam int DEPTH     = 4;
  localparam int LATCH_LOW = 2700;
`ifdef NEOPIX_RX_PASSTHRU_EN
  localparam bit PASSTHRU = 1'b1;
`else
  localparam bit PASSTHRU = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        di = 1'b0;
  logic        ready = 1'b0;
  logic [23:0] pix;
  logic        sof, valid, frame_end, overflow, bsy, dout;
  logic [15:0] pix_count;

  int n_checks = 0;
  int n_fail = 0;
  logic [24:0] exp_q[$];
  logic [24:0] head;
  bit ovf_exp = 1'b0;
  bit decoding = 1'b1;
  bit fwd_expect = 1'b0;
  int frame_pix = 0;
  int bits_in_frame = 0;
  int fe_cnt = 0;
  int fe_exp = 0;
  int do_errs = 0;
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  neopix_rx dut (
    .clk_i       (clk),
    .reset_ni    (rst_n),
    .di_i        (di),
    .pix_o       (pix),
    .pix_sof_o   (sof),
    .pix_valid_o (valid),
    .pix_ready_i (ready),
    .frame_end_o (frame_end),
    .pix_count_o (pix_count),
    .overflow_o  (overflow),
    .bsy_o       (bsy),
    .do_o        (dout)
  );

  // clock / reset
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: a pixel enters the model when its last bit ends on the line
  task automatic model_push(input logic [23:0] p);
    if (!PASSTHRU || frame_pix == 0) begin
      if (!ready && exp_q.size() >= DEPTH) ovf_exp = 1'b1;
      else exp_q.push_back({frame_pix == 0, p});
    end
    frame_pix++;
  endtask

  // drivers (all called at a negedge)
  task automatic send_bit(input bit b, input bit glitch);
    int h, l;
    h = b ? $urandom_range(40, 34) : $urandom_range(20, 12);
    l = $urandom_range(30, 20);
    di = 1'b1;
    wait_cycles(h);
    di = 1'b0;
    if (decoding) bits_in_frame++;
    wait_cycles(l);
    if (glitch) begin
      di = 1'b1;
      wait_cycles($urandom_range(5, 2));
      di = 1'b0;
      wait_cycles($urandom_range(20, 12));
    end
  endtask

  task automatic send_pixel(input logic [23:0] p, input int glitch_at, input bit measure);
    int h, lat;
    for (int i = 23; i >= 1; i--) send_bit(p[i], (23 - i) == glitch_at);
    h = p[0] ? $urandom_range(40, 34) : $urandom_range(20, 12);
    di = 1'b1;
    wait_cycles(h);
    di = 1'b0;
    if (decoding) begin
      bits_in_frame++;
      model_push(p);
    end
    if (measure) begin
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (valid && lat == 0) lat = k;
      end
      check("latency", lat, 4);
    end
    wait_cycles($urandom_range(30, 20));
    if (decoding && PASSTHRU) fwd_expect = 1'b1;
  endtask

  task automatic end_frame();
    wait_cycles(LATCH_LOW);
    if (bits_in_frame > 0) fe_exp++;
    check("frame_end_cnt", fe_cnt, fe_exp);
    if (bits_in_frame > 0)
      check("pix_count", pix_count, PASSTHRU ? 32'(frame_pix > 0) : 32'(frame_pix));
    check("bsy_after_latch", bsy, 1'b0);
    check("overflow", overflow, ovf_exp);
    frame_pix = 0;
    bits_in_frame = 0;
    fwd_expect = 1'b0;
  endtask

  always @(posedge clk) begin
    h2 = h1;
    h1 = h0;
    h0 = di;
  end

  // monitor: pops, frame_end pulses, do_o against the line delayed through the synchroniser
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (valid && ready) begin
        check("pop_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          head = exp_q.pop_front();
          check("pix", pix, head[23:0]);
          check("sof", sof, head[24]);
        end
      end
      if (frame_end) fe_cnt++;
      if (dout !== (fwd_expect ? h2 : 1'b0)) do_errs++;
    end
  end

  initial begin
    int n;
    wait_cycles(4);
    check("rst_pix", pix, 0);
    check("rst_sof", sof, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_pix_count", pix_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_bsy", bsy, 0);
    check("rst_do", dout, 0);
    rst_n = 1'b1;
    wait_cycles(LATCH_LOW);

    // single known pixel with latency measurement
    ready = 1'b1;
    send_pixel(24'hA53C0F, -1, 1'b1);
    check("bsy_in_frame", bsy, 1'b1);
    end_frame();
    check("q_drained_1", exp_q.size(), 0);

    // glitch between bits 7 and 8
    send_pixel(24'hA53C0F, 7, 1'b0);
    end_frame();
    check("q_drained_2", exp_q.size(), 0);

    // overflow with consumer stalled
    ready = 1'b0;
    for (int v = 1; v <= 5; v++) send_pixel(24'(v), -1, 1'b0);
    end_frame();
    check("held_valid", valid, 1'b1);
    check("held_pix", pix, 24'h000001);
    check("held_sof", sof, 1'b1);
    wait_cycles(5);
    check("held_pix_stable", pix, 24'h000001);
    ready = 1'b1;
    wait_cycles(10);
    check("q_drained_3", exp_q.size(), 0);
    check("valid_after_drain", valid, 1'b0);

    // reset during bit 10, then mid-stream data must be ignored until a latch
    for (int i = 0; i < 9; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    di = 1'b1;
    wait_cycles(10);
    rst_n = 1'b0;
    di = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
    frame_pix = 0;
    bits_in_frame = 0;
    wait_cycles(3);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_pix_count", pix_count, 0);
    check("mid_rst_bsy", bsy, 1'b0);
    rst_n = 1'b1;
    decoding = 1'b0;
    wait_cycles(1500);
    send_pixel(24'($urandom), -1, 1'b0);
    check("sync_no_bsy", bsy, 1'b0);
    end_frame();
    check("sync_no_valid", valid, 1'b0);
    decoding = 1'b1;
    send_pixel(24'($urandom), -1, 1'b0);
    end_frame();
    check("q_drained_5", exp_q.size(), 0);

    // partial pixel only
    for (int i = 0; i < 12; i++) send_bit(1'($urandom_range(1, 0)), 1'b0);
    end_frame();
    check("partial_no_valid", valid, 1'b0);

    // random frames with occasional glitches
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(3, 1);
      for (int j = 0; j < n; j++)
        send_pixel(24'($urandom), ($urandom_range(3, 0) == 0) ? int'($urandom_range(22, 0)) : -1, 1'b0);
      end_frame();
      check("q_drained_rand", exp_q.size(), 0);
    end

    check("do_o_errors", do_errs, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
